// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM. Duty writes land in a pending bank. The pending
// bank, mode and polarity are applied together at each period boundary.
module pwm_multi #(
  parameter int N_CH       = 3,
  parameter int RES        = 7,
  parameter int DIV_FAST   = 10416,
  parameter int DIV_SLOW   = 200000,
  parameter int SERVO_MIN  = 6,
  parameter int SERVO_SPAN = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  localparam int DIV_MAX = (DIV_FAST > DIV_SLOW) ? DIV_FAST : DIV_SLOW;
  localparam int QW      = $clog2(DIV_MAX + 1);

  logic [QW-1:0]   q;
  logic [QW-1:0]   q_last;
  logic [RES-1:0]  cnt;
  logic [RES-1:0]  pending [N_CH];
  logic [RES-1:0]  active  [N_CH];
  logic [31:0]     thr     [N_CH];
  logic            mode;
  logic            inv;
  logic            strobe_q;
  logic [N_CH-1:0] pwm;
  logic            tick;
  logic            boundary;
  logic            wr_edge;
  logic [2:0]      addr;
  logic            unused_in;

  assign addr      = uio_in[2:0];
  assign wr_edge   = uio_in[3] & ~strobe_q;
  assign q_last    = mode ? QW'(DIV_SLOW - 1) : QW'(DIV_FAST - 1);
  assign tick      = ena & (q == q_last);
  assign boundary  = tick & (&cnt);
  assign unused_in = ^{uio_in[7:6], ui_in};

  // Servo thresholds are widened to 32 bits so the scaled product never truncates.
  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      thr[k] = 32'(active[k]);
      if (mode) begin
        thr[k] = 32'(SERVO_MIN) + ((32'(active[k]) * 32'(SERVO_SPAN)) >> RES);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q        <= '0;
      cnt      <= '0;
      mode     <= 1'b0;
      inv      <= 1'b0;
      strobe_q <= 1'b0;
      pwm      <= '0;
      for (int k = 0; k < N_CH; k++) begin
        pending[k] <= '0;
        active[k]  <= '0;
      end
    end else begin
      strobe_q <= uio_in[3];
      for (int k = 0; k < N_CH; k++) begin
        if (wr_edge && (addr == 3'(k))) pending[k] <= ui_in[RES-1:0];
        // Nonblocking load: a write on the boundary edge misses this period.
        if (boundary) active[k] <= pending[k];
        pwm[k] <= ena ? ((32'(cnt) < thr[k]) ^ inv) : inv;
      end
      if (ena) begin
        q <= tick ? '0 : q + QW'(1);
        if (tick) cnt <= cnt + RES'(1);
      end
      if (boundary) begin
        mode <= uio_in[4];
        inv  <= uio_in[5];
      end
    end
  end

  always_comb begin
    uo_out = '0;
    uo_out[N_CH-1:0] = pwm;
  end

  assign uio_out = '0;
  assign uio_oe  = '0;

endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: scoreboard bench; a period-position model predicts uo_out each
// clock, and a monitor compares the DUT one half-cycle after each edge.
module tb_pwm_multi;
  localparam int N_CH = 3, RES = 4, DIV_FAST = 2, DIV_SLOW = 4;
  localparam int SERVO_MIN = 2, SERVO_SPAN = 4;
  localparam int STEPS = 1 << RES;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;

  pwm_multi #(
    .N_CH(N_CH), .RES(RES), .DIV_FAST(DIV_FAST), .DIV_SLOW(DIV_SLOW),
    .SERVO_MIN(SERVO_MIN), .SERVO_SPAN(SERVO_SPAN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  logic [7:0] sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int n_cyc = 0;

  // Model state: position within the current period in clocks.
  int m_pos = 0;
  int m_pending[N_CH];
  int m_active[N_CH];
  int m_mode = 0;
  int m_inv = 0;
  bit m_strb = 1'b0;

  function automatic int div_of(int md);
    return md ? DIV_SLOW : DIV_FAST;
  endfunction

  function automatic int per_of(int md);
    return STEPS * div_of(md);
  endfunction

  function automatic int thr_of(int duty, int md);
    return md ? SERVO_MIN + ((duty * SERVO_SPAN) >> RES) : duty;
  endfunction

  task automatic model_edge();
    logic [7:0] exp_out;
    int old_pend[N_CH];
    int step;
    exp_out = 8'h00;
    if (!rst_n) begin
      m_pos = 0; m_mode = 0; m_inv = 0; m_strb = 1'b0;
      for (int k = 0; k < N_CH; k++) begin m_pending[k] = 0; m_active[k] = 0; end
    end else begin
      step = m_pos / div_of(m_mode);
      for (int k = 0; k < N_CH; k++)
        exp_out[k] = ena ? ((step < thr_of(m_active[k], m_mode)) ^ (m_inv != 0)) : (m_inv != 0);
      old_pend = m_pending;
      if (uio_in[3] && !m_strb && int'(uio_in[2:0]) < N_CH)
        m_pending[int'(uio_in[2:0])] = int'(ui_in[RES-1:0]);
      m_strb = uio_in[3];
      if (ena) begin
        if (m_pos == per_of(m_mode) - 1) begin
          m_active = old_pend;
          m_mode = int'(uio_in[4]);
          m_inv = int'(uio_in[5]);
          m_pos = 0;
        end else begin
          m_pos++;
        end
      end
    end
    sb.push_back(exp_out);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    n_cyc++;
    @(negedge clk);
  endtask

  task automatic run(int n);
    repeat (n) cycle();
  endtask

  task automatic wr(int a, int d);
    uio_in[2:0] = a[2:0];
    ui_in = d[7:0];
    uio_in[3] = 1'b1;
    cycle();
    uio_in[3] = 1'b0;
    cycle();
  endtask

  // Advance until the model sits at the given period position; bounded.
  task automatic seek(int target, string name);
    int i;
    i = 0;
    while (m_pos != target && i < 300) begin cycle(); i++; end
    n_cmp++;
    if (m_pos != target) begin
      n_bad++;
      $display("FAIL seek_%s: position %0d, required %0d", name, m_pos, target);
    end
  endtask

  initial begin : monitor
    logic [7:0] exp_out;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        exp_out = sb.pop_front();
        n_cmp++;
        if (uo_out !== exp_out || uio_out !== 8'h00 || uio_oe !== 8'h00) begin
          n_bad++;
          $display("FAIL outputs cycle %0d: uo_out=%h uio_out=%h uio_oe=%h, required %h/00/00",
                   n_cyc, uo_out, uio_out, uio_oe, exp_out);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: time limit reached, %0d compared / %0d bad", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst_n = 1'b0; ena = 1'b1;
    run(2);
    rst_n = 1'b1;
    run(32);
    wr(0, 4);
    run(80);
    wr(1, 0);
    wr(2, 15);
    run(70);
    uio_in[5] = 1'b1;
    run(70);
    uio_in[5] = 1'b0;
    run(40);
    uio_in[4] = 1'b1;
    wr(0, 8);
    run(140);
    seek(per_of(m_mode) - 1, "boundary");
    uio_in[2:0] = 3'd0; ui_in = 8'd9; uio_in[3] = 1'b1;
    cycle();
    uio_in[3] = 1'b0;
    run(140);
    wr(5, 3);
    run(70);
    seek(per_of(m_mode) / 2, "midperiod");
    ena = 1'b0;
    run(10);
    ena = 1'b1;
    run(140);
    uio_in[4] = 1'b0;
    run(90);
    rst_n = 1'b0;
    run(1);
    rst_n = 1'b1;
    wr(1, 7);
    run(80);
    for (int i = 0; i < 1500; i++) begin
      rst_n = ($urandom_range(0, 399) != 0);
      ena = ($urandom_range(0, 15) != 0);
      if (uio_in[3]) uio_in[3] = 1'b0;
      else if ($urandom_range(0, 4) == 0) begin
        uio_in[2:0] = 3'($urandom_range(0, 7));
        ui_in = 8'($urandom);
        uio_in[3] = 1'b1;
      end
      if ($urandom_range(0, 99) == 0) uio_in[4] = ~uio_in[4];
      if ($urandom_range(0, 99) == 0) uio_in[5] = ~uio_in[5];
      uio_in[7:6] = 2'($urandom);
      cycle();
    end
    rst_n = 1'b1; ena = 1'b1; uio_in[3] = 1'b0;
    run(10);
    @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected values left unchecked, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pwm_multi.md
PWM_MULTI -- requirements
Module: pwm_multi

Interface
REQ-001 SHALL have parameter N_CH, default 3, number of PWM channels (1..8).
REQ-002 SHALL have parameter RES, default 7, duty/period-counter width in bits (2..8).
REQ-003 SHALL have parameter DIV_FAST, default 10416, prescaler clocks per step in mode 0.
REQ-004 SHALL have parameter DIV_SLOW, default 200000, prescaler clocks per step in mode 1.
REQ-005 SHALL have parameter SERVO_MIN, default 6, servo minimum pulse in steps.
REQ-006 SHALL have parameter SERVO_SPAN, default 7, servo pulse range in steps.
REQ-007 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-008 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-009 SHALL have port ena  input  1  run enable.
REQ-010 SHALL have port ui_in  input  8  write data; duty = ui_in[RES-1:0].
REQ-011 SHALL have port uio_in  input  8  [2:0] channel address, [3] write strobe, [4] mode (0 linear/DIV_FAST, 1 servo/DIV_SLOW), [5] output invert, [7:6] ignored.
REQ-012 SHALL have port uo_out  output  8  bit k = channel k PWM, k<N_CH; bits >=N_CH tied 0.
REQ-013 SHALL have port uio_out  output  8  constant 0.
REQ-014 SHALL have port uio_oe  output  8  constant 0 (all uio pins inputs).

Function
REQ-015 Write: SHALL register uio_in[3] and detect its 0->1 edge; on that edge pending[addr] <= ui_in[RES-1:0], one write per edge.
REQ-016 Writes with addr >= N_CH SHALL be ignored; multiple writes to one channel within a period: last wins.
REQ-017 Prescaler q SHALL count 0..DIV-1 (DIV per active mode), wrap to 0, and assert tick in the cycle q==DIV-1.
REQ-018 Step counter cnt (RES bits) SHALL increment on tick, wrapping 2^RES-1 -> 0; period = 2^RES*DIV clocks.
REQ-019 Boundary = tick with cnt==2^RES-1; at boundary, active[k] <= pending[k] for all k, active mode <= uio_in[4], active invert <= uio_in[5].
REQ-020 Write edge in the same cycle as boundary: boundary SHALL load the pre-write pending value; new value applies one period later.
REQ-021 Threshold mode 0: thr[k] = active[k]; mode 1: thr[k] = SERVO_MIN + ((active[k]*SERVO_SPAN) >> RES), product computed at full width, no truncation.
REQ-022 Output register: pwm[k] <= (cnt < thr[k]) XOR invert every enabled clock; 1-clock latency from cnt change.
REQ-023 Duty 0 in mode 0 SHALL give constant idle level; duty 2^RES-1 SHALL give active level for (2^RES-1)*DIV of 2^RES*DIV clocks.
REQ-024 ena=0: q, cnt, pending-load and outputs SHALL freeze at their current values except pwm[k] forced to invert level; writes still accepted into pending; ena=1 resumes from frozen q/cnt.
REQ-025 Mode change SHALL take effect only at boundary; DIV in use switches with active mode, q restarts at 0.

Reset
REQ-026 rst_n=0 at a clk edge SHALL set q=0, cnt=0, all pending/active=0, active mode=0, invert=0, strobe register=0, uo_out=0.
REQ-027 Reset asserted mid-period SHALL abort the period; first post-reset boundary occurs 2^RES*DIV_FAST clocks after release.
REQ-028 uio_out and uio_oe SHALL be 0 at all times, including reset.

Verification (bench params N_CH=3, RES=4, DIV_FAST=2, DIV_SLOW=4, SERVO_MIN=2, SERVO_SPAN=4)
REQ-029 rst_n low 2 clocks, ena=1 -> uo_out=0x00, uio_out=0x00, uio_oe=0x00, held 32 clocks.
REQ-030 Write ch0=4 (mode 0) -> after next boundary ch0 high 8 of every 32 clocks, ch1/ch2 low.
REQ-031 ch1=0, ch2=15 -> ch1 always low; ch2 high 30 of 32 clocks; invert=1 -> complement from next boundary.
REQ-032 mode=1, ch0=8 -> thr=4, ch0 high 16 clocks per 64-clock period, starting at next boundary.
REQ-033 Write ch0=9 coincident with boundary -> old duty one more period, 9 afterward; write addr 5 -> no channel changes.
REQ-034 ena low 10 clocks mid-period -> uo_out at idle level, counters frozen; after ena=1 remaining period length unchanged.
